// File: rtl/cache_mem_arbiter_if.sv
// Cache/RAM bus bundle shared by the icache, dcache and RAM sides.
// The arbiter takes the slave view; the caches and RAM take the master view.
interface cache_mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  ramload, ramstate,
      output iwait, iload, dwait, dload,
      output ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      output ramload, ramstate,
      input  iwait, iload, dwait, dload,
      input  ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache; dcache has priority,
// with a bounded dcache burst so the icache always makes progress.
module cache_mem_arbiter #(
   parameter int MAX_DBURST = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   cache_mem_arbiter_if.slave  bus,
   output logic                ram_err
);
   localparam int CW = $clog2(MAX_DBURST) + 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_DBURST - 1);
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   typedef enum logic [1:0] {IDLE, DOWN, IOWN} owner_t;
   typedef enum logic [1:0] {G_NONE, G_D, G_I} grant_t;

   owner_t        state;
   grant_t        grant;
   logic [CW-1:0] burst;
   logic          dreq;
   logic          d_acc;
   logic          i_acc;
   logic          force_i;
   logic          leave_down;

   assign dreq = bus.dREN | bus.dWEN;

   // Grant is gated by nRST so a reset pulse drops the RAM port at once.
   always_comb begin
      grant = G_NONE;
      if (nRST) begin
         unique case (state)
            IDLE: begin
               if (dreq)          grant = G_D;
               else if (bus.iREN) grant = G_I;
            end
            DOWN: if (dreq)     grant = G_D;
            IOWN: if (bus.iREN) grant = G_I;
            default: grant = G_NONE;
         endcase
      end
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      if (grant == G_D) begin
         bus.ramWEN   = bus.dWEN;
         bus.ramREN   = bus.dREN & ~bus.dWEN;
         bus.ramaddr  = bus.daddr;
         bus.ramstore = bus.dstore;
      end else if (grant == G_I) begin
         bus.ramREN   = 1'b1;
         bus.ramaddr  = bus.iaddr;
      end
   end

   assign d_acc     = (grant == G_D) && (bus.ramstate == ACCESS);
   assign i_acc     = (grant == G_I) && (bus.ramstate == ACCESS);
   assign bus.dwait = ~d_acc;
   assign bus.iwait = ~i_acc;
   assign bus.iload = bus.ramload;
   assign bus.dload = bus.ramload;

   assign force_i    = d_acc && bus.iREN && (burst == LAST);
   assign leave_down = (state == DOWN) && (!dreq || force_i);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         burst   <= '0;
         ram_err <= 1'b0;
      end else begin
         if (grant != G_NONE && bus.ramstate == ERROR)
            ram_err <= 1'b1;
         unique case (state)
            IDLE: begin
               if (grant == G_D)      state <= DOWN;
               else if (grant == G_I) state <= IOWN;
            end
            DOWN: begin
               if (!dreq)        state <= IDLE;
               else if (force_i) state <= IOWN;
            end
            IOWN: if (i_acc || !bus.iREN) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (!bus.iREN || i_acc || leave_down)
            burst <= '0;
         else if (d_acc)
            burst <= burst + CW'(1);
      end
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: cache drivers push expected
// completions, a negedge monitor pops and compares them in order.
module tb_cache_mem_arbiter;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic ram_err;

   always #5 CLK = ~CLK;

   cache_mem_arbiter_if bus ();

   cache_mem_arbiter #(.MAX_DBURST(4)) dut (
      .CLK(CLK),
      .nRST(nRST),
      .bus(bus),
      .ram_err(ram_err)
   );

   typedef struct {
      logic        src_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;

   function automatic logic [31:0] ram_data(input logic [31:0] a);
      if (a == 32'h40) return 32'h2402000A;
      return a ^ 32'hA5A50000;
   endfunction

   // RAM model: BUSY for lat cycles, then ACCESS for one cycle.
   int   lat = 2;
   int   rcnt = 0;
   logic force_err = 1'b0;
   logic ram_en;
   assign ram_en      = bus.ramREN | bus.ramWEN;
   assign bus.ramload = ram_data(bus.ramaddr);

   always_comb begin
      bus.ramstate = 2'd0;
      if (ram_en) begin
         if (force_err)       bus.ramstate = 2'd3;
         else if (rcnt >= lat) bus.ramstate = 2'd2;
         else                 bus.ramstate = 2'd1;
      end
   end

   always @(posedge CLK) begin
      if (!ram_en || bus.ramstate == 2'd2) rcnt <= 0;
      else if (bus.ramstate == 2'd1)       rcnt <= rcnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic d, input logic we,
                       input logic [31:0] a, input logic [31:0] dat);
      exp_t e;
      e.src_d = d;
      e.we    = we;
      e.addr  = a;
      e.data  = dat;
      sbq.push_back(e);
   endtask

   task automatic check_pop(input logic is_d);
      exp_t e;
      if (sbq.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected completion: src_d %0d addr %h expected none",
                  is_d, bus.ramaddr);
         return;
      end
      e = sbq.pop_front();
      chk("completion source", 32'(is_d), 32'(e.src_d));
      chk("completion addr", bus.ramaddr, e.addr);
      if (e.we) begin
         chk("write ramWEN", 32'(bus.ramWEN), 32'd1);
         chk("write ramREN", 32'(bus.ramREN), 32'd0);
         chk("write ramstore", bus.ramstore, e.data);
      end else if (is_d) begin
         chk("dload", bus.dload, e.data);
      end else begin
         chk("iload", bus.iload, e.data);
      end
   endtask

   always @(negedge CLK) begin
      if (nRST) begin
         if (!bus.dwait) check_pop(1'b1);
         if (!bus.iwait) check_pop(1'b0);
      end
   end

   task automatic wait_done(input logic is_d, input string nm);
      int n = 0;
      forever begin
         @(negedge CLK);
         if (is_d ? !bus.dwait : !bus.iwait) break;
         n++;
         if (n > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout got no completion expected one", nm);
            break;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic d_word(input logic we, input logic [31:0] a,
                         input logic [31:0] dat);
      bus.dWEN   = we;
      bus.dREN   = ~we;
      bus.daddr  = a;
      bus.dstore = dat;
      wait_done(1'b1, "dcache word");
   endtask

   task automatic d_idle();
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
   endtask

   task automatic i_word(input logic [31:0] a);
      bus.iREN  = 1'b1;
      bus.iaddr = a;
      wait_done(1'b0, "icache word");
      bus.iREN  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iREN = 1'b1;
      bus.iaddr = 32'h0;
      bus.dREN = 1'b1;
      bus.dWEN = 1'b0;
      bus.daddr = 32'h0;
      bus.dstore = 32'h0;
      #1;
      chk("reset ramREN", 32'(bus.ramREN), 32'd0);
      chk("reset ramWEN", 32'(bus.ramWEN), 32'd0);
      chk("reset iwait", 32'(bus.iwait), 32'd1);
      chk("reset dwait", 32'(bus.dwait), 32'd1);
      chk("reset ram_err", 32'(ram_err), 32'd0);
      d_idle();
      bus.iREN = 1'b0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      @(posedge CLK);
      #1;

      // 1: single icache fetch, ACCESS on the third cycle
      push(1'b0, 1'b0, 32'h40, 32'h2402000A);
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h40;
      @(negedge CLK);
      chk("t1 iwait cycle1", 32'(bus.iwait), 32'd1);
      @(negedge CLK);
      chk("t1 iwait cycle2", 32'(bus.iwait), 32'd1);
      @(negedge CLK);
      chk("t1 iwait cycle3", 32'(bus.iwait), 32'd0);
      @(posedge CLK);
      #1 bus.iREN = 1'b0;
      @(negedge CLK);
      chk("t1 idle ramREN", 32'(bus.ramREN), 32'd0);
      chk("t1 idle iwait", 32'(bus.iwait), 32'd1);
      @(posedge CLK);
      #1;

      // 2: simultaneous requests, dcache first
      push(1'b1, 1'b0, 32'h100, ram_data(32'h100));
      push(1'b0, 1'b0, 32'h44, ram_data(32'h44));
      fork
         begin
            d_word(1'b0, 32'h100, 32'h0);
            d_idle();
         end
         i_word(32'h44);
         begin
            @(negedge CLK);
            chk("t2 first ramaddr", bus.ramaddr, 32'h100);
            chk("t2 icache stalled", 32'(bus.iwait), 32'd1);
         end
      join
      @(posedge CLK);
      #1;

      // 3: four-word writeback+fill ahead of a pending icache fetch
      push(1'b1, 1'b1, 32'h3100, 32'h11112222);
      push(1'b1, 1'b1, 32'h3104, 32'h33334444);
      push(1'b1, 1'b0, 32'h200, ram_data(32'h200));
      push(1'b1, 1'b0, 32'h204, ram_data(32'h204));
      push(1'b0, 1'b0, 32'h48, ram_data(32'h48));
      fork
         begin
            d_word(1'b1, 32'h3100, 32'h11112222);
            d_word(1'b1, 32'h3104, 32'h33334444);
            d_word(1'b0, 32'h200, 32'h0);
            d_word(1'b0, 32'h204, 32'h0);
            d_idle();
         end
         i_word(32'h48);
      join
      @(posedge CLK);
      #1;

      // 4: six dcache words, icache forced in after the fourth
      for (int k = 0; k < 4; k++)
         push(1'b1, 1'b0, 32'h500 + 32'(4 * k), ram_data(32'h500 + 32'(4 * k)));
      push(1'b0, 1'b0, 32'h4C, ram_data(32'h4C));
      push(1'b1, 1'b0, 32'h510, ram_data(32'h510));
      push(1'b1, 1'b0, 32'h514, ram_data(32'h514));
      fork
         begin
            for (int k = 0; k < 6; k++)
               d_word(1'b0, 32'h500 + 32'(4 * k), 32'h0);
            d_idle();
         end
         i_word(32'h4C);
      join
      @(posedge CLK);
      #1;

      // 5: write wins when dWEN and dREN are both high
      push(1'b1, 1'b1, 32'h80, 32'hDEADBEEF);
      bus.dWEN   = 1'b1;
      bus.dREN   = 1'b1;
      bus.daddr  = 32'h80;
      bus.dstore = 32'hDEADBEEF;
      @(negedge CLK);
      chk("t5 ramWEN", 32'(bus.ramWEN), 32'd1);
      chk("t5 ramREN", 32'(bus.ramREN), 32'd0);
      chk("t5 ramstore", bus.ramstore, 32'hDEADBEEF);
      wait_done(1'b1, "t5 write");
      d_idle();
      @(posedge CLK);
      #1;

      // 6: RAM error is sticky and stalls the dcache
      force_err  = 1'b1;
      bus.dREN   = 1'b1;
      bus.daddr  = 32'h300;
      @(negedge CLK);
      chk("t6 ram_err before edge", 32'(ram_err), 32'd0);
      chk("t6 dwait on error", 32'(bus.dwait), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("t6 dwait held", 32'(bus.dwait), 32'd1);
         chk("t6 ram_err set", 32'(ram_err), 32'd1);
      end
      @(posedge CLK);
      #1;
      force_err = 1'b0;
      d_idle();
      @(negedge CLK);
      chk("t6 ram_err sticky", 32'(ram_err), 32'd1);
      chk("t6 free ramREN", 32'(bus.ramREN), 32'd0);
      @(posedge CLK);
      #1;

      // 6b: reset pulse mid-transfer
      bus.dREN  = 1'b1;
      bus.daddr = 32'h600;
      @(negedge CLK);
      chk("t6 pre-reset ramREN", 32'(bus.ramREN), 32'd1);
      @(posedge CLK);
      #2 nRST = 1'b0;
      #1;
      chk("t6 reset ramREN", 32'(bus.ramREN), 32'd0);
      chk("t6 reset ramWEN", 32'(bus.ramWEN), 32'd0);
      chk("t6 reset ramaddr", bus.ramaddr, 32'h0);
      chk("t6 reset dwait", 32'(bus.dwait), 32'd1);
      chk("t6 reset ram_err", 32'(ram_err), 32'd0);
      d_idle();
      @(posedge CLK);
      #1 nRST = 1'b1;
      @(negedge CLK);
      chk("t6 post-reset ramREN", 32'(bus.ramREN), 32'd0);
      @(posedge CLK);
      #1;

      chk("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
